// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM state codes, parity type, line levels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional macro: UART_TX_PARITY_EN adds the PARITY state to state_t.
package uart_pkg;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PARITY_ENC = 3'd3;
    localparam logic [2:0] ST_STOP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE_ENC,
        S_START  = ST_START_ENC,
        S_DATA   = ST_DATA_ENC,
`ifdef UART_TX_PARITY_EN
        S_PARITY = ST_PARITY_ENC,
`endif
        S_STOP   = ST_STOP_ENC
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// Parity bit generator: XOR-reduce of the latched byte, inverted for odd parity.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: data (WIDTH bits), par_typ (0 even / 1 odd) -> par_bit.
// Present only when UART_TX_PARITY_EN is defined; the default build has no parity logic.
`ifdef UART_TX_PARITY_EN
module parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);
    import uart_pkg::*;

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule
`endif

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: latches a byte, launches the serializer, frames start/data/[parity]/stop.
// Latency: data_valid_tx accepted at edge N puts the start bit on TX_OUT in cycle N+1.
// Backpressure: requests are accepted only in IDLE or STOP; requests in other states are dropped, not queued.
// Ports: clk_tx/rst_tx (async active-low); P_DATA_tx + data_valid_tx request in;
//        ser_en_tx/P_DATA_out_tx drive the serializer, ser_data_tx/ser_done_tx come back;
//        TX_OUT serial line (idle high), busy_tx frame in progress.
// Optional macro: UART_TX_PARITY_EN adds par_en_tx/par_typ_tx ports and the PARITY state.
module uart_tx_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk_tx,
    input  logic             rst_tx,
    input  logic [WIDTH-1:0] P_DATA_tx,
    input  logic             data_valid_tx,
`ifdef UART_TX_PARITY_EN
    input  logic             par_en_tx,
    input  logic             par_typ_tx,
`endif
    input  logic             ser_done_tx,
    input  logic             ser_data_tx,
    output logic             ser_en_tx,
    output logic [WIDTH-1:0] P_DATA_out_tx,
    output logic             TX_OUT,
    output logic             busy_tx
);
    import uart_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] data_q;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;

    parity_calc #(.WIDTH(WIDTH)) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );
`endif

    assign P_DATA_out_tx = data_q;

    // busy_tx and ser_en_tx are registered from the next-state decision so they
    // line up with the state they describe.
    always_ff @(posedge clk_tx or negedge rst_tx) begin
        if (!rst_tx) begin
            state     <= S_IDLE;
            data_q    <= '0;
            busy_tx   <= 1'b0;
            ser_en_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
`endif
        end else begin
            ser_en_tx <= 1'b0;
            case (state)
                // STOP shares the accept path with IDLE so back-to-back frames
                // go straight from stop bit to start bit.
                S_IDLE, S_STOP: begin
                    if (data_valid_tx) begin
                        data_q    <= P_DATA_tx;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= par_en_tx;
                        par_typ_q <= par_typ_tx;
`endif
                        state     <= S_START;
                        busy_tx   <= 1'b1;
                        ser_en_tx <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        busy_tx <= 1'b0;
                    end
                end
                S_START: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (ser_done_tx) begin
`ifdef UART_TX_PARITY_EN
                        state <= par_en_q ? S_PARITY : S_STOP;
`else
                        state <= S_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    state <= S_STOP;
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    busy_tx <= 1'b0;
                end
            endcase
        end
    end

    // Line level decodes only the state register and registered sources, so
    // reset forces the idle level without waiting for a clock edge.
    always_comb begin
        TX_OUT = IDLE_LEVEL;
        case (state)
            S_START:  TX_OUT = START_LEVEL;
            S_DATA:   TX_OUT = ser_data_tx;
`ifdef UART_TX_PARITY_EN
            S_PARITY: TX_OUT = par_bit;
`endif
            S_STOP:   TX_OUT = STOP_LEVEL;
            default:  TX_OUT = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: directed frames, expected per-cycle line state queued by stimulus,
// popped and compared each falling edge by an independent monitor.
module tb_uart_tx_fsm;

    localparam int WIDTH = 8;

    logic             clk_tx = 1'b0;
    logic             rst_tx = 1'b0;
    logic [WIDTH-1:0] P_DATA_tx = '0;
    logic             data_valid_tx = 1'b0;
    logic             par_en_tx = 1'b0;
    logic             par_typ_tx = 1'b0;
    logic             ser_done_tx;
    logic             ser_data_tx;
    logic             ser_en_tx;
    logic [WIDTH-1:0] P_DATA_out_tx;
    logic             TX_OUT;
    logic             busy_tx;

    always #5 clk_tx = ~clk_tx;

    uart_tx_fsm #(.WIDTH(WIDTH)) dut (
        .clk_tx        (clk_tx),
        .rst_tx        (rst_tx),
        .P_DATA_tx     (P_DATA_tx),
        .data_valid_tx (data_valid_tx),
`ifdef UART_TX_PARITY_EN
        .par_en_tx     (par_en_tx),
        .par_typ_tx    (par_typ_tx),
`endif
        .ser_done_tx   (ser_done_tx),
        .ser_data_tx   (ser_data_tx),
        .ser_en_tx     (ser_en_tx),
        .P_DATA_out_tx (P_DATA_out_tx),
        .TX_OUT        (TX_OUT),
        .busy_tx       (busy_tx)
    );

    // Serializer stand-in: loads on ser_en_tx, presents bit 0 in the first DATA
    // cycle and raises done alongside the last bit.
    logic [WIDTH-1:0] sh;
    logic [3:0]       cnt;
    logic             act;

    always @(posedge clk_tx or negedge rst_tx) begin
        if (!rst_tx) begin
            sh  <= '0;
            cnt <= '0;
            act <= 1'b0;
        end else if (ser_en_tx) begin
            sh  <= P_DATA_out_tx;
            cnt <= '0;
            act <= 1'b1;
        end else if (act) begin
            sh  <= sh >> 1;
            cnt <= cnt + 4'd1;
            if (cnt == 4'(WIDTH - 1)) act <= 1'b0;
        end
    end

    assign ser_data_tx = sh[0];
    assign ser_done_tx = act && (cnt == 4'(WIDTH - 1));

    typedef struct {
        logic             tx;
        logic             bz;
        logic             se;
        logic [WIDTH-1:0] pd;
        string            nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [WIDTH-1:0] cur_pdo = '0;

    task automatic push(input logic tx, input logic bz, input logic se,
                        input logic [WIDTH-1:0] pd, input string nm);
        exp_t x;
        x.tx = tx; x.bz = bz; x.se = se; x.pd = pd; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d, input bit par_on,
                              input logic pbit, input string tag);
        push(1'b0, 1'b1, 1'b1, d, {tag, "_start"});
        for (int i = 0; i < WIDTH; i++)
            push(d[i], 1'b1, 1'b0, d, $sformatf("%s_d%0d", tag, i));
        if (par_on) push(pbit, 1'b1, 1'b0, d, {tag, "_par"});
        push(1'b1, 1'b1, 1'b0, d, {tag, "_stop"});
    endtask

    task automatic push_idle(input int n, input logic [WIDTH-1:0] pd, input string nm);
        for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, pd, nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(posedge clk_tx);
        end
        n_checks++;
        if (q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: wait expired with %0d expected records pending", q.size());
    endtask

    task automatic check_reset(input string nm);
        n_checks++;
        if ({TX_OUT, busy_tx, ser_en_tx} === 3'b100)
            n_pass++;
        else
            $display("FAIL %s: got tx=%b busy=%b ser_en=%b, want tx=1 busy=0 ser_en=0",
                     nm, TX_OUT, busy_tx, ser_en_tx);
    endtask

    // Request in the current (idle) cycle; acceptance happens at the next edge.
    task automatic request(input logic [WIDTH-1:0] d, input logic pe, input logic pt);
        @(posedge clk_tx);
        #1;
        data_valid_tx = 1'b1;
        P_DATA_tx     = d;
        par_en_tx     = pe;
        par_typ_tx    = pt;
        push(1'b1, 1'b0, 1'b0, cur_pdo, "pre_accept");
        cur_pdo = d;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk_tx);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({TX_OUT, busy_tx, ser_en_tx, P_DATA_out_tx} === {e.tx, e.bz, e.se, e.pd})
                    n_pass++;
                else
                    $display("FAIL %s: got tx=%b busy=%b ser_en=%b pdata=%02h, want tx=%b busy=%b ser_en=%b pdata=%02h",
                             e.nm, TX_OUT, busy_tx, ser_en_tx, P_DATA_out_tx, e.tx, e.bz, e.se, e.pd);
            end
        end
    end

    initial begin
        // Reset state held, then released.
        push_idle(5, 8'h00, "reset");
        repeat (3) @(posedge clk_tx);
        #1 check_reset("reset_held");
        rst_tx = 1'b1;
        drain();

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
        request(8'hA5, 1'b0, 1'b0);
        push_frame(8'hA5, 1'b0, 1'b0, "a5");
        push_idle(2, 8'hA5, "a5_idle");
        @(posedge clk_tx); #1 data_valid_tx = 1'b0;
        drain();

`ifdef UART_TX_PARITY_EN
        // 0xA5 has four ones: even parity bit 0, odd parity bit 1.
        request(8'hA5, 1'b1, 1'b0);
        push_frame(8'hA5, 1'b1, 1'b0, "a5_even");
        push_idle(2, 8'hA5, "a5_even_idle");
        @(posedge clk_tx); #1 data_valid_tx = 1'b0; par_en_tx = 1'b0;
        drain();

        request(8'hA5, 1'b1, 1'b1);
        push_frame(8'hA5, 1'b1, 1'b1, "a5_odd");
        push_idle(2, 8'hA5, "a5_odd_idle");
        @(posedge clk_tx); #1 data_valid_tx = 1'b0; par_en_tx = 1'b0; par_typ_tx = 1'b0;
        drain();
`endif

        // Back-to-back: 0x3C accepted, input switched to 0x0F with valid held,
        // accepted again in STOP with no idle gap.
        request(8'h3C, 1'b0, 1'b0);
        push_frame(8'h3C, 1'b0, 1'b0, "b2b1");
        push_frame(8'h0F, 1'b0, 1'b0, "b2b2");
        push_idle(2, 8'h0F, "b2b_idle");
        @(posedge clk_tx); #1 P_DATA_tx = 8'h0F;
        repeat (10) @(posedge clk_tx);
        #1 data_valid_tx = 1'b0;
        cur_pdo = 8'h0F;
        drain();

        // 0xFF request in the 3rd DATA cycle of a 0x00 frame is dropped.
        request(8'h00, 1'b0, 1'b0);
        push_frame(8'h00, 1'b0, 1'b0, "zero");
        push_idle(3, 8'h00, "zero_idle");
        @(posedge clk_tx); #1 data_valid_tx = 1'b0;
        repeat (3) @(posedge clk_tx);
        #1 data_valid_tx = 1'b1; P_DATA_tx = 8'hFF;
        @(posedge clk_tx); #1 data_valid_tx = 1'b0;
        drain();

        // Reset in the 4th DATA cycle of 0x5A: line high and not busy at once.
        request(8'h5A, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, 8'h5A, "rst_start");
        push(1'b0, 1'b1, 1'b0, 8'h5A, "rst_d0");
        push(1'b1, 1'b1, 1'b0, 8'h5A, "rst_d1");
        push(1'b0, 1'b1, 1'b0, 8'h5A, "rst_d2");
        push_idle(3, 8'h00, "rst_abort");
        @(posedge clk_tx); #1 data_valid_tx = 1'b0;
        repeat (4) @(posedge clk_tx);
        #1 rst_tx = 1'b0;
        #1 check_reset("rst_async");
        repeat (2) @(posedge clk_tx);
        #1 rst_tx = 1'b1;
        cur_pdo = 8'h00;
        drain();

        // Clean frame after the abandoned one.
        request(8'hC3, 1'b0, 1'b0);
        push_frame(8'hC3, 1'b0, 1'b0, "after_rst");
        push_idle(2, 8'hC3, "after_rst_idle");
        @(posedge clk_tx); #1 data_valid_tx = 1'b0;
        drain();

        repeat (2) @(posedge clk_tx);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame controller for the UART transmit path, sitting directly upstream of the serializer and driving the TX line. It accepts a parallel byte with a valid strobe and latches it. It launches the serializer and frames its output as start bit, data bits (LSB first), optional parity and stop bit. One clock cycle equals one bit period; the baud-rate clock is generated outside this block.

## Interface
- WIDTH, 8, data bits per frame. Legal range 1..15, set by the serializer's 4-bit counter.
- clk_tx  input  1  bit-rate clock, rising edge.
- rst_tx  input  1  asynchronous, active-low reset.
- P_DATA_tx  input  WIDTH  byte to send. Sampled only on an accepted data_valid_tx.
- data_valid_tx  input  1  request strobe. Accepted in IDLE or STOP only; ignored otherwise.
- par_en_tx  input  1  parity enable. Sampled with data. Present only with the macro.
- par_typ_tx  input  1  0 = even, 1 = odd. Sampled with data. Present only with the macro.
- ser_done_tx  input  1  serializer done; high during the cycle the last data bit is on ser_data_tx.
- ser_data_tx  input  1  serializer output bit.
- ser_en_tx  output  1  one-cycle load pulse to the serializer.
- P_DATA_out_tx  output  WIDTH  latched byte, driven to the serializer's parallel input.
- TX_OUT  output  1  serial line, idle high.
- busy_tx  output  1  high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding comes from the package.
- IDLE
  - TX_OUT=1, busy_tx=0.
  - If data_valid_tx=1, latch P_DATA_tx (and parity controls), then go to START.
- START
  - TX_OUT=0, ser_en_tx=1, busy_tx=1.
  - The serializer loads the latched byte at the edge leaving START.
  - Always goes to DATA.
- DATA
  - TX_OUT=ser_data_tx.
  - If ser_done_tx=1, go to PARITY when parity is enabled, else to STOP.
- PARITY
  - TX_OUT=par_bit.
  - par_bit = XOR of the latched byte, inverted when the latched par_typ=1.
  - Always goes to STOP.
- STOP
  - TX_OUT=1, busy_tx=1.
  - If data_valid_tx=1, latch the new data and go to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- TX_OUT is a pure decode of the state register and registered sources (ser_data_tx, par_bit). No combinational path from data_valid_tx or P_DATA_tx to TX_OUT.
- The data latch holds its value from acceptance until the next acceptance. Changes on P_DATA_tx mid-frame have no effect.

## Timing
- Reset values:
  - state=IDLE, TX_OUT=1, busy_tx=0, ser_en_tx=0, P_DATA_out_tx=0.
  - Parity latches clear to 0.
- Latency: data_valid_tx sampled at edge N gives the start bit on TX_OUT in cycle N+1.
- Frame length: 1+WIDTH+1 cycles without parity, 1+WIDTH+2 cycles with parity. With WIDTH=8 that is 10 or 11.
- DATA lasts exactly WIDTH cycles with a compliant serializer: bit 0 in the first DATA cycle, ser_done_tx in the WIDTH-th.
- busy_tx rises one cycle after acceptance and falls on entry to IDLE. It stays high across back-to-back frames.
- Simultaneous events:
  - data_valid_tx in START, DATA or PARITY is ignored; no queuing.
  - data_valid_tx in STOP is accepted.
- Reset mid-frame: return to IDLE immediately. TX_OUT=1 asynchronously; the frame is abandoned with no stop bit.
- ser_done_tx outside DATA is ignored.

## Configuration
- UART_TX_PARITY_EN
  - Defined: par_en_tx and par_typ_tx ports, the PARITY state and parity logic are present.
  - Undefined: those ports and the state are absent; DATA always goes to STOP and frames are 1+WIDTH+1 cycles.

## Structure
- Package uart_pkg:
  - state encoding localparams.
  - PAR_EVEN=0, PAR_ODD=1.
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- Sub-module parity_calc: combinational XOR-reduce of WIDTH bits with type select. Instantiated only under UART_TX_PARITY_EN.

## Test plan
- Reset held low, then released: TX_OUT=1, busy_tx=0, ser_en_tx=0.
- 0xA5, parity disabled, data_valid_tx one cycle:
  - ser_en_tx pulses in the start cycle.
  - TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles.
  - busy_tx high for exactly 10 cycles.
- 0xA5, parity enabled:
  - even: parity bit 0, frame 11 cycles.
  - odd: parity bit 1.
- Back-to-back: data_valid_tx with 0x0F held through STOP.
  - The next start bit follows the stop bit directly.
  - busy_tx never drops; second frame data = 1,1,1,1,0,0,0,0.
- data_valid_tx with 0xFF pulsed in the 3rd DATA cycle of a 0x00 frame: ignored; the frame completes as all-zero data, then IDLE.
- rst_tx asserted in the 4th DATA cycle: TX_OUT=1 and busy_tx=0 immediately; the next accepted byte yields a clean full frame.
